// File: rtl/lt24_frame_streamer.sv
// Autonomous LT24 (ILI9341 8080-style) refresh engine: fetches background and
// foreground pixels, applies a colour key and streams one frame to the LCD.
module lt24_frame_streamer #(
    parameter int                H_RES       = 240,
    parameter int                V_RES       = 320,
    parameter int                SCALE_SH    = 1,
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 16,
    parameter int                MEM_LAT     = 1,
    parameter int                WR_LOW_CYC  = 2,
    parameter int                WR_HIGH_CYC = 2,
    parameter logic [DATA_W-1:0] KEY_COLOR   = 'hF81F,
    parameter logic [7:0]        CMD_MEMWR   = 8'h2C
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic                start,
    input  logic                fg_enable,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   bg_address,
    output logic                bg_chipselect,
    output logic                bg_clken,
    output logic                bg_write,
    output logic [DATA_W-1:0]   bg_writedata,
    output logic [DATA_W/8-1:0] bg_byteenable,
    input  logic [DATA_W-1:0]   bg_readdata,
    output logic [ADDR_W-1:0]   fg_address,
    output logic                fg_chipselect,
    output logic                fg_clken,
    output logic                fg_write,
    output logic [DATA_W-1:0]   fg_writedata,
    output logic [DATA_W/8-1:0] fg_byteenable,
    input  logic [DATA_W-1:0]   fg_readdata,
    output logic                lt24_cs,
    output logic                lt24_rs,
    output logic                lt24_rd,
    output logic                lt24_wr,
    output logic [DATA_W-1:0]   lt24_data
);

    localparam int XW       = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW       = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int MAX_A    = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
    localparam int MAX_C    = (MAX_A > MEM_LAT) ? MAX_A : MEM_LAT;
    localparam int CW       = $clog2(MAX_C + 1);
    localparam int SCALED_W = H_RES >> SCALE_SH;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD_LO, S_CMD_HI, S_FETCH, S_WAIT, S_WR_LO, S_WR_HI, S_DONE
    } state_t;

    state_t            state;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [CW-1:0]     cnt;
    logic              fg_en_q;
    logic [ADDR_W-1:0] address;
    logic              rd_strobe;

    logic [XW-1:0]     x_next;
    logic [YW-1:0]     y_next;
    logic              last_px;
    logic [DATA_W-1:0] pixel;

    // Scaled word address; widened to 32 bits so the product cannot wrap
    // before the final truncation to ADDR_W.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [XW-1:0] px,
                                                     input logic [YW-1:0] py);
        logic [31:0] full;
        full = 32'(py >> SCALE_SH) * 32'(SCALED_W) + 32'(px >> SCALE_SH);
        return full[ADDR_W-1:0];
    endfunction

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        last_px = (x == XW'(H_RES - 1)) && (y == YW'(V_RES - 1));
        x_next  = x + XW'(1);
        y_next  = y;
        if (x == XW'(H_RES - 1)) begin
            x_next = '0;
            y_next = y + YW'(1);
        end
        pixel = (fg_en_q && (fg_readdata != KEY_COLOR)) ? fg_readdata : bg_readdata;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state     <= S_IDLE;
            x         <= '0;
            y         <= '0;
            cnt       <= '0;
            fg_en_q   <= 1'b0;
            address   <= '0;
            rd_strobe <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            lt24_cs   <= 1'b1;
            lt24_rs   <= 1'b1;
            lt24_wr   <= 1'b1;
            lt24_data <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    fg_en_q   <= fg_enable;
                    busy      <= 1'b1;
                    lt24_cs   <= 1'b0;
                    lt24_rs   <= 1'b0;
                    lt24_wr   <= 1'b0;
                    lt24_data <= {{(DATA_W-8){1'b0}}, CMD_MEMWR};
                    cnt       <= CW'(WR_LOW_CYC - 1);
                    state     <= S_CMD_LO;
                end
                S_CMD_LO, S_WR_LO: begin
                    if (cnt == '0) begin
                        lt24_wr <= 1'b1;
                        cnt     <= CW'(WR_HIGH_CYC - 1);
                        state   <= (state == S_CMD_LO) ? S_CMD_HI : S_WR_HI;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_CMD_HI: begin
                    if (cnt == '0) begin
                        address   <= word_addr(x, y);
                        rd_strobe <= 1'b1;
                        state     <= S_FETCH;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_FETCH: begin
                    rd_strobe <= 1'b0;
                    cnt       <= CW'(MEM_LAT - 1);
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    // Read data is valid in the last wait cycle; it is held
                    // on the bus through the whole low and high phase.
                    if (cnt == '0) begin
                        lt24_data <= pixel;
                        lt24_rs   <= 1'b1;
                        lt24_wr   <= 1'b0;
                        cnt       <= CW'(WR_LOW_CYC - 1);
                        state     <= S_WR_LO;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_WR_HI: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (last_px) begin
                        x       <= '0;
                        y       <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        lt24_cs <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        x         <= x_next;
                        y         <= y_next;
                        address   <= word_addr(x_next, y_next);
                        rd_strobe <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bg_address    = address;
    assign fg_address    = address;
    assign bg_chipselect = rd_strobe;
    assign fg_chipselect = rd_strobe;
    assign bg_clken      = rd_strobe;
    assign fg_clken      = rd_strobe;
    assign bg_write      = 1'b0;
    assign fg_write      = 1'b0;
    assign bg_writedata  = '0;
    assign fg_writedata  = '0;
    assign bg_byteenable = '1;
    assign fg_byteenable = '1;
    assign lt24_rd       = 1'b1;

endmodule

// File: doc/lt24_frame_streamer.md
Name: lt24_frame_streamer

Overview:
- Autonomous LT24 (ILI9341, 8080-style 16-bit) refresh engine.
- Reads pixels from two on-chip dual-port RAMs through their second ports: a background memory and a foreground/picture memory. It composites them with a colour key and streams one full frame to the LCD bus.
- Generalises the fixed-size memory/LCD pairing: resolution, memory scaling, bus timing and read latency are all parameters.
- Sits beside the SOPC; the CPU fills the memories via their first ports and the block is kicked by a start pulse.

Parameters:
- H_RES, 240, pixels per line (x counter range 0..H_RES-1)
- V_RES, 320, lines per frame (y counter range 0..V_RES-1)
- SCALE_SH, 1, memory downscale shift; memory holds (H_RES>>SCALE_SH)*(V_RES>>SCALE_SH) words
- ADDR_W, 16, memory address width; must hold the scaled word count
- DATA_W, 16, pixel/bus width
- MEM_LAT, 1, read latency in cycles from address to readdata valid (1..3)
- WR_LOW_CYC, 2, cycles wr_n held low per bus write (>=1)
- WR_HIGH_CYC, 2, cycles wr_n held high after each write (>=1)
- KEY_COLOR, 16'hF81F, foreground value treated as transparent
- CMD_MEMWR, 8'h2C, command issued before pixel data

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  async active-low reset
- start  in  1  one-cycle frame request
- fg_enable  in  1  sampled at start; 0 = background only
- busy  out  1  high from accepted start until frame done
- done  out  1  one-cycle pulse after last pixel write completes
- bg_address, fg_address  out  ADDR_W  memory word address (shared value)
- bg_chipselect, fg_chipselect  out  1  read strobe
- bg_clken, fg_clken  out  1  equals chipselect
- bg_write, fg_write  out  1  constant 0
- bg_writedata, fg_writedata  out  DATA_W  constant 0
- bg_byteenable, fg_byteenable  out  DATA_W/8  constant all ones
- bg_readdata, fg_readdata  in  DATA_W  read data, valid MEM_LAT cycles after address
- lt24_cs  out  1  chip select, active low
- lt24_rs  out  1  0 = command, 1 = data
- lt24_rd  out  1  constant 1
- lt24_wr  out  1  write strobe, active low; LCD latches on rising edge
- lt24_data  out  DATA_W  bus data

Behaviour:
- Reset values: lt24_cs=1, lt24_rs=1, lt24_rd=1, lt24_wr=1, lt24_data=0, busy=0, done=0, chipselects=0, address=0. Internal state is IDLE and x=y=0.
- Reset asserted mid-frame aborts immediately to these values. There is no partial resume.
- IDLE: start=1 registers fg_enable, sets busy=1 and enters CMD.
- start while busy is ignored.
- CMD:
  - lt24_cs=0, lt24_rs=0, data={0,CMD_MEMWR}.
  - wr low WR_LOW_CYC cycles, then high WR_HIGH_CYC cycles.
  - Then FETCH.
- FETCH:
  - address=(y>>SCALE_SH)*(H_RES>>SCALE_SH)+(x>>SCALE_SH).
  - chipselect/clken=1 for exactly 1 cycle.
  - Wait MEM_LAT cycles, then capture pixel.
- Pixel capture: pixel = (fg_enable_reg && fg_readdata!=KEY_COLOR) ? fg_readdata : bg_readdata.
- WR_LO: rs=1, data=pixel, wr=0 for WR_LOW_CYC cycles. Data is stable throughout and for the entire following high phase.
- WR_HI: wr=1 for WR_HIGH_CYC cycles, then advance the counters:
  - x increments.
  - At x=H_RES-1, x wraps to 0 and y increments.
  - At x=H_RES-1 and y=V_RES-1, go to DONE; otherwise go to FETCH.
- Pixel period = 1 + MEM_LAT + WR_LOW_CYC + WR_HIGH_CYC cycles. The frame issues exactly H_RES*V_RES data writes plus 1 command write.
- DONE (1 cycle): done=1, busy=0, lt24_cs=1, x=y=0, then IDLE. A start on the DONE cycle is ignored; it is accepted from the next cycle onward.
- lt24_cs stays low continuously from the first CMD cycle to the last WR_HI cycle.
- Address arithmetic is unsigned and computed at full width before truncation to ADDR_W.

Test Plan:
- Reset mid-frame:
  - Stimulus: H_RES=4, V_RES=2, SCALE_SH=0, MEM_LAT=1, WR 1/1. Reset asserted at pixel 3.
  - Required: all outputs return to reset values asynchronously. A new start then produces a full frame beginning with command 0x2C.
- Basic frame:
  - Stimulus: same parameters (no reset), bg RAM = address value, fg_enable=0.
  - Required: one rs=0 write of 0x002C, then 8 rs=1 writes with data 0..7.
  - Required: pixel period 4 cycles; done pulses once; busy high throughout the frame.
- Colour key:
  - Stimulus: fg RAM = {KEY,0x1234,KEY,0x0001,...}, fg_enable=1.
  - Required: writes are bg[0], 0x1234, bg[2], 0x0001, ...
- Scaling:
  - Stimulus: SCALE_SH=1, H_RES=4, V_RES=4.
  - Required: address sequence 0,0,1,1,0,0,1,1,2,2,3,3,2,2,3,3.
- Latency and timing:
  - Stimulus: MEM_LAT=3, WR_LOW_CYC=3, WR_HIGH_CYC=2.
  - Required: wr low exactly 3 cycles and high at least 2 cycles per write; data constant across each low+high window; captured data matches readdata 3 cycles after address.
- Start handling:
  - Stimulus: start pulses during busy, and on the DONE cycle.
  - Required: both ignored, with no extra command write. A start 1 cycle after DONE begins a new frame.
